// File: rtl/regularization_mc.sv
// regularization_mc: per-channel debounce/dwell regularizer; REGULARIZATION_MC_STATS_EN adds o_glitch_count
module regularization_mc #(
  parameter int N = 4,
  parameter int CW = 16,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [N-1:0]  i_signal,
  input  logic [N-1:0]  i_enable,
  input  logic [CW-1:0] i_debounce_time,
  input  logic [CW-1:0] i_dwell_time,
`ifdef REGULARIZATION_MC_STATS_EN
  output logic [N*16-1:0] o_glitch_count,
`endif
  output logic [N-1:0]  o_signal,
  output logic [N-1:0]  o_change,
  output logic [N-1:0]  o_locked
);
  typedef enum logic [1:0] {STABLE, DEBOUNCE, LOCK} state_t;
  logic [CW-1:0] thr;
  logic no_dwell;
  assign thr = (i_debounce_time == '0) ? CW'(1) : i_debounce_time;
  assign no_dwell = (i_dwell_time == '0);
  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t st, nst;
    logic [CW-1:0] db, lk, ndb, nlk;
    logic s, out, chg, nout, nchg;
    always_ff @(posedge i_clk)
      if (!i_reset) begin
        st <= STABLE;
        db <= '0;
        lk <= '0;
        s <= RESET_VALUE[i];
        out <= RESET_VALUE[i];
        chg <= 1'b0;
      end else begin
        st <= nst;
        db <= ndb;
        lk <= nlk;
        s <= i_signal[i];
        out <= nout;
        chg <= nchg;
      end
    always_comb begin
      nst = st;
      ndb = db;
      nlk = lk;
      nout = out;
      nchg = 1'b0;
      if (!i_enable[i]) begin
        nst = STABLE;
        ndb = '0;
        nlk = '0;
        nout = s;
      end else if (st == STABLE) begin
        nst = (s != out) ? DEBOUNCE : STABLE;
        ndb = (s != out) ? CW'(1) : '0;
      end else if (st == DEBOUNCE) begin
        if (s == out) begin
          nst = STABLE;
          ndb = '0;
        end else if (db >= thr) begin
          nout = ~out;
          nchg = 1'b1;
          ndb = '0;
          nst = no_dwell ? STABLE : LOCK;
          nlk = no_dwell ? '0 : CW'(1);
        end else
          ndb = db + 1'b1;
      end else if (lk >= i_dwell_time) begin
        nst = STABLE;
        nlk = '0;
      end else
        nlk = lk + 1'b1;
    end
    assign o_signal[i] = out;
    assign o_change[i] = chg;
    assign o_locked[i] = (st == LOCK);
`ifdef REGULARIZATION_MC_STATS_EN
    logic [15:0] gc;
    logic glitch;
    assign glitch = i_enable[i] && (st == DEBOUNCE) && (s == out);
    always_ff @(posedge i_clk)
      if (!i_reset) gc <= '0;
      else if (glitch && gc != 16'hFFFF) gc <= gc + 16'd1;
    assign o_glitch_count[16*i +: 16] = gc;
`endif
  end
endmodule

// File: tb/tb_regularization_mc.sv
// tb_regularization_mc: randomized check of regularization_mc against a cycle-level behavioural model
module tb_regularization_mc;
  localparam int N = 4;
  localparam int CW = 16;
  localparam logic [N-1:0] RV = 4'b1010;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  logic [N-1:0] i_signal = RV;
  logic [N-1:0] i_enable = '1;
  logic [CW-1:0] i_debounce_time = 16'd3;
  logic [CW-1:0] i_dwell_time = 16'd0;
  logic [N-1:0] o_signal, o_change, o_locked;
`ifdef REGULARIZATION_MC_STATS_EN
  logic [N*16-1:0] o_glitch_count;
`endif
  int n_cmp = 0;
  int n_err = 0;
  bit m_out[N], m_s[N], m_chg[N], m_lock[N];
  int m_run[N], m_el[N], m_gc[N];
  always #5 i_clk = ~i_clk;
  regularization_mc #(.N(N), .CW(CW), .RESET_VALUE(RV)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_signal(i_signal),
    .i_enable(i_enable),
    .i_debounce_time(i_debounce_time),
    .i_dwell_time(i_dwell_time),
`ifdef REGULARIZATION_MC_STATS_EN
    .o_glitch_count(o_glitch_count),
`endif
    .o_signal(o_signal),
    .o_change(o_change),
    .o_locked(o_locked)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  // one clock edge of the specified behaviour, using the inputs present at the edge
  function automatic void model_step();
    int t = (i_debounce_time == 0) ? 1 : int'(i_debounce_time);
    for (int c = 0; c < N; c++) begin
      m_chg[c] = 0;
      if (!i_reset) begin
        m_out[c] = RV[c]; m_s[c] = RV[c]; m_run[c] = 0; m_el[c] = 0; m_lock[c] = 0; m_gc[c] = 0;
        continue;
      end
      if (!i_enable[c]) begin
        m_out[c] = m_s[c]; m_run[c] = 0; m_lock[c] = 0;
      end else if (m_lock[c]) begin
        if (m_el[c] >= int'(i_dwell_time)) m_lock[c] = 0;
        else m_el[c]++;
      end else if (m_s[c] == m_out[c]) begin
        if (m_run[c] > 0 && m_gc[c] < 65535) m_gc[c]++;
        m_run[c] = 0;
      end else if (m_run[c] >= t) begin
        m_out[c] = !m_out[c];
        m_chg[c] = 1;
        m_run[c] = 0;
        if (i_dwell_time != 0) begin m_lock[c] = 1; m_el[c] = 1; end
      end else m_run[c]++;
      m_s[c] = i_signal[c];
    end
  endfunction
  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    for (int c = 0; c < N; c++) begin
      check($sformatf("sig%0d", c), 32'(o_signal[c]), 32'(m_out[c]));
      check($sformatf("chg%0d", c), 32'(o_change[c]), 32'(m_chg[c]));
      check($sformatf("lock%0d", c), 32'(o_locked[c]), 32'(m_lock[c]));
`ifdef REGULARIZATION_MC_STATS_EN
      check($sformatf("gc%0d", c), 32'(o_glitch_count[16*c +: 16]), 32'(m_gc[c]));
`endif
    end
  endtask
  initial begin
    repeat (3) tick();
    i_reset = 1'b1;
    for (int p = 0; p < 24; p++) begin
      int flip = $urandom_range(2, 12);
      i_debounce_time = 16'($urandom_range(0, 5));
      i_dwell_time = 16'($urandom_range(0, 6));
      for (int k = 0; k < 100; k++) begin
        for (int c = 0; c < N; c++) begin
          if ($urandom_range(1, flip) == 1) i_signal[c] = ~i_signal[c];
          if ($urandom_range(1, 40) == 1) i_enable[c] = ~i_enable[c];
        end
        if ($urandom_range(1, 60) == 1) i_debounce_time = 16'($urandom_range(0, 5));
        if ($urandom_range(1, 60) == 1) i_dwell_time = 16'($urandom_range(0, 6));
        i_reset = ($urandom_range(1, 150) != 1);
        tick();
      end
      if (p == 12) i_enable = '1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
